// File: rtl/local_input_buffer_pkg.sv
// Shared definitions for the router local-port input buffer: packet width,
// header field map and upstream acceptance FSM encodings.
package local_input_buffer_pkg;

  localparam int PKT_W = 56;

  // Header field map; the buffer forwards packets untouched.
  localparam int PKT_ID_LSB  = 0;
  localparam int PKT_ID_W    = 10;
  localparam int MOD_ID_LSB  = 10;
  localparam int MOD_ID_W    = 6;
  localparam int RAND_LSB    = 16;
  localparam int RAND_W      = 10;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_GNT  = 2'd1,
    ACC_REL  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/local_input_buffer_sync_fifo_fwft.sv
// First-word-fall-through FIFO: head entry is visible on o_data whenever
// the FIFO holds data; occupancy is a dedicated counter.
module sync_fifo_fwft
  import local_input_buffer_pkg::*;
#(
  parameter int W      = PKT_W,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [W-1:0]      i_data,
  input  logic              i_pop,
  output logic [W-1:0]      o_data,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count
);

  logic [W-1:0]      r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  assign w_empty = (r_count == '0);
  assign o_full  = (r_count == (ADDR_W+1)'(DEPTH));
  // Pops on an empty FIFO and pushes on a full one are dropped here.
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && !o_full;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is masked to zero when empty so stale data never leaks out.
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/local_input_buffer.sv
// Router local-port input buffer: injector Req/Gnt acceptance FSM in front
// of a FWFT FIFO, presenting the head packet to the routing stage.
module local_input_buffer
  import local_input_buffer_pkg::*;
#(
  parameter int         packetwidth = PKT_W,
  parameter int         DEPTH       = 4,
  parameter int         ADDR_W      = 2,
  parameter logic [5:0] routerID    = 6'b000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ReqUpStr,
  input  logic [packetwidth-1:0] PacketIn,
  output logic                   GntUpStr,
  output logic                   UpStrFull,
  output logic                   ReqDnStr,
  output logic [packetwidth-1:0] PacketOut,
  input  logic                   GntDnStr,
  output logic [ADDR_W:0]        Occupancy,
  output logic [15:0]            PktCount
);

  acc_state_t  r_state;
  acc_state_t  w_next_state;
  logic        w_accept;
  logic [15:0] r_pkt_count;
  logic        w_unused_cfg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ACC_IDLE;
    else        r_state <= w_next_state;
  end

  // ACC_REL holds until the injector drops Req, so a late-dropped request
  // is never accepted twice.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ACC_IDLE: begin
        if (ReqUpStr && !UpStrFull) begin
          w_accept     = 1'b1;
          w_next_state = ACC_GNT;
        end
      end
      ACC_GNT: w_next_state = ACC_REL;
      ACC_REL: if (!ReqUpStr) w_next_state = ACC_IDLE;
      default: w_next_state = ACC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_pkt_count <= '0;
    else if (w_accept) r_pkt_count <= r_pkt_count + 1'b1;
  end

  sync_fifo_fwft #(
    .W      (packetwidth),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_accept),
    .i_data  (PacketIn),
    .i_pop   (GntDnStr),
    .o_data  (PacketOut),
    .o_full  (UpStrFull),
    .o_count (Occupancy)
  );

  assign GntUpStr = (r_state == ACC_GNT);
  assign ReqDnStr = (Occupancy != '0);
  assign PktCount = r_pkt_count;

  // Router ID and header field map are informational only.
  assign w_unused_cfg = ^{routerID,
                          PacketOut[PKT_ID_LSB +: PKT_ID_W],
                          PacketOut[MOD_ID_LSB +: MOD_ID_W],
                          PacketOut[RAND_LSB +: RAND_W]};

endmodule

// File: tb/tb_local_input_buffer.sv
// Self-checking bench for local_input_buffer: literal vector table, directed
// corner-case sequences and randomized traffic against a queue-based model.
module tb_local_input_buffer;

  localparam int PW    = 56;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          ReqUpStr;
  logic [PW-1:0] PacketIn;
  logic          GntUpStr;
  logic          UpStrFull;
  logic          ReqDnStr;
  logic [PW-1:0] PacketOut;
  logic          GntDnStr;
  logic [AW:0]   Occupancy;
  logic [15:0]   PktCount;

  always #5 clk = ~clk;

  local_input_buffer #(
    .packetwidth (PW),
    .DEPTH       (DEPTH),
    .ADDR_W      (AW),
    .routerID    (6'b000_011)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ReqUpStr  (ReqUpStr),
    .PacketIn  (PacketIn),
    .GntUpStr  (GntUpStr),
    .UpStrFull (UpStrFull),
    .ReqDnStr  (ReqDnStr),
    .PacketOut (PacketOut),
    .GntDnStr  (GntDnStr),
    .Occupancy (Occupancy),
    .PktCount  (PktCount)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of stored packets plus handshake bookkeeping.
  logic [PW-1:0] m_q[$];
  bit            m_granted;   // grant pulse is being shown this cycle
  bit            m_wait_drop; // waiting for the injector to drop Req
  logic [15:0]   m_cnt;
  logic [PW-1:0] popped[$];

  typedef struct {
    bit            req;
    logic [PW-1:0] pkt;
    bit            gdn;
    bit            e_gnt;
    bit            e_full;
    bit            e_rdn;
    int            e_occ;
    int            e_cnt;
    logic [PW-1:0] e_out;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_granted   = 1'b0;
    m_wait_drop = 1'b0;
    m_cnt       = '0;
  endtask

  task automatic model_step(input bit req, input logic [PW-1:0] pkt, input bit gdn);
    bit acc;
    bit pop;
    acc = !m_granted && !m_wait_drop && req && (m_q.size() < DEPTH);
    pop = gdn && (m_q.size() > 0);
    m_wait_drop = m_granted || (m_wait_drop && req);
    m_granted   = acc;
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back(pkt);
      m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic check_model(input string tag);
    logic [PW-1:0] head;
    head = (m_q.size() > 0) ? m_q[0] : '0;
    chk({tag, ".GntUpStr"},  GntUpStr,  m_granted);
    chk({tag, ".UpStrFull"}, UpStrFull, m_q.size() == DEPTH);
    chk({tag, ".ReqDnStr"},  ReqDnStr,  m_q.size() > 0);
    chk({tag, ".Occupancy"}, Occupancy, m_q.size());
    chk({tag, ".PktCount"},  PktCount,  m_cnt);
    chk({tag, ".PacketOut"}, PacketOut, head);
  endtask

  // One clock: drive, record any pop, clock, step model, compare at edge+1.
  task automatic cycle(input bit req, input logic [PW-1:0] pkt, input bit gdn);
    ReqUpStr = req;
    PacketIn = pkt;
    GntDnStr = gdn;
    if (gdn && ReqDnStr) popped.push_back(PacketOut);
    @(posedge clk);
    model_step(req, pkt, gdn);
    #1;
    check_model("model");
  endtask

  task automatic push(input logic [PW-1:0] pkt, input bit g1, input bit g2);
    int t;
    t = 0;
    do begin
      cycle(1'b1, pkt, 1'b0);
      t++;
    end while (!GntUpStr && t < 40);
    if (!GntUpStr) chk("push.grant_timeout", GntUpStr, 1);
    cycle(1'b0, '0, g1);
    cycle(1'b0, '0, g2);
  endtask

  task automatic do_reset();
    ReqUpStr = 1'b0;
    GntDnStr = 1'b0;
    PacketIn = '0;
    reset    = 1'b0;
    #1;
    chk("reset.GntUpStr",  GntUpStr,  0);
    chk("reset.ReqDnStr",  ReqDnStr,  0);
    chk("reset.Occupancy", Occupancy, 0);
    chk("reset.PktCount",  PktCount,  0);
    chk("reset.PacketOut", PacketOut, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    popped.delete();
  endtask

  initial begin
    logic [PW-1:0] pa, pb, pc;
    pa = 56'h0000_0000_1A2B_3C;
    pb = 56'h00AB_CDEF_0123_45;
    pc = 56'hFF_FFFF_FFFF_FFFF;
    //            req pkt gdn gnt full rdn occ cnt out
    tbl[0] = '{1'b1, pa, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1, pa};
    tbl[1] = '{1'b1, pa, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, pa};
    tbl[2] = '{1'b1, pb, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, pa};
    tbl[3] = '{1'b0, pb, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, pa};
    tbl[4] = '{1'b1, pb, 1'b0, 1'b1, 1'b0, 1'b1, 2, 2, pa};
    tbl[5] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 2, pb};
    tbl[6] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2, '0};
    tbl[7] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2, '0};
    tbl[8] = '{1'b1, pc, 1'b0, 1'b1, 1'b0, 1'b1, 1, 3, pc};

    reset    = 1'b0;
    ReqUpStr = 1'b0;
    GntDnStr = 1'b0;
    PacketIn = '0;
    model_reset();

    // Vector table: single packet, held Req, pops, empty pop.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].req, tbl[i].pkt, tbl[i].gdn);
      chk($sformatf("tbl%0d.GntUpStr", i),  GntUpStr,  tbl[i].e_gnt);
      chk($sformatf("tbl%0d.UpStrFull", i), UpStrFull, tbl[i].e_full);
      chk($sformatf("tbl%0d.ReqDnStr", i),  ReqDnStr,  tbl[i].e_rdn);
      chk($sformatf("tbl%0d.Occupancy", i), Occupancy, tbl[i].e_occ);
      chk($sformatf("tbl%0d.PktCount", i),  PktCount,  tbl[i].e_cnt);
      chk($sformatf("tbl%0d.PacketOut", i), PacketOut, tbl[i].e_out);
    end

    // Fill to full, hold off a fifth request, release with one pop.
    do_reset();
    for (int i = 1; i <= 4; i++) push(PW'(i), 1'b0, 1'b0);
    chk("fill.UpStrFull", UpStrFull, 1);
    chk("fill.Occupancy", Occupancy, 4);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, PW'(5), 1'b0);
      chk("fill.held_no_grant", GntUpStr, 0);
    end
    cycle(1'b1, PW'(5), 1'b1);
    chk("fill.pop_full_drop", UpStrFull, 0);
    chk("fill.pop_occ", Occupancy, 3);
    chk("fill.pop_no_grant_yet", GntUpStr, 0);
    cycle(1'b1, PW'(5), 1'b0);
    chk("fill.fifth_grant", GntUpStr, 1);
    chk("fill.fifth_occ", Occupancy, 4);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    popped.delete();
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
    chk("fill.drain_count", popped.size(), 4);
    for (int i = 0; i < popped.size() && i < 4; i++)
      chk($sformatf("fill.order%0d", i), popped[i], i + 2);

    // Grant-write edge coinciding with a pop.
    do_reset();
    push(PW'(10), 1'b0, 1'b0);
    push(PW'(11), 1'b0, 1'b0);
    chk("simul.pre_occ", Occupancy, 2);
    cycle(1'b1, PW'(12), 1'b1);
    chk("simul.grant", GntUpStr, 1);
    chk("simul.occ", Occupancy, 2);
    chk("simul.head", PacketOut, 11);

    // Pops while empty are ignored.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("empty.occ", Occupancy, 0);
      chk("empty.reqdn", ReqDnStr, 0);
    end
    push(PW'(77), 1'b0, 1'b0);
    chk("empty.after_head", PacketOut, 77);
    chk("empty.after_occ", Occupancy, 1);

    // Stream ten packets with interleaved pops through the wrapping pointers.
    do_reset();
    for (int i = 0; i < 10; i++) push(PW'(56'h3C_0000_0000_0000 + i), i[0], i[0]);
    for (int i = 0; i < 12 && ReqDnStr; i++) cycle(1'b0, '0, 1'b1);
    chk("wrap.count", popped.size(), 10);
    for (int i = 0; i < popped.size() && i < 10; i++)
      chk($sformatf("wrap.pkt%0d", i), popped[i], 56'h3C_0000_0000_0000 + i);

    // PktCount wraps from 65535 to 0.
    do_reset();
    force dut.r_pkt_count = 16'hFFFF;
    #1;
    release dut.r_pkt_count;
    m_cnt = 16'hFFFF;
    chk("wrapcnt.preset", PktCount, 16'hFFFF);
    push(PW'(1), 1'b0, 1'b0);
    chk("wrapcnt.zero", PktCount, 0);

    // Asynchronous reset while in the grant cycle with three stored.
    do_reset();
    push(PW'(1), 1'b0, 1'b0);
    push(PW'(2), 1'b0, 1'b0);
    cycle(1'b1, PW'(3), 1'b0);
    chk("rst.pre_grant", GntUpStr, 1);
    chk("rst.pre_occ", Occupancy, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("rst.async_gnt", GntUpStr, 0);
    chk("rst.async_reqdn", ReqDnStr, 0);
    chk("rst.async_occ", Occupancy, 0);
    chk("rst.async_out", PacketOut, 0);
    model_reset();
    ReqUpStr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1'b1, PW'(9), 1'b0);
    chk("rst.after_grant", GntUpStr, 1);
    chk("rst.after_head", PacketOut, 9);
    chk("rst.after_cnt", PktCount, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      logic [PW-1:0] rp;
      rp = {$urandom, $urandom};
      cycle($urandom_range(0, 3) != 0, rp, $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/local_input_buffer.md
Name: local_input_buffer

Overview:
- Router local-port input buffer that sits directly downstream of each PE injector.
- Upstream side: accepts packets over the injector Req/Gnt/Full handshake.
- Storage: a small first-word-fall-through FIFO.
- Downstream side: presents the head packet to the router's routing/arbitration stage over its own Req/Gnt handshake.

Parameters:
- packetwidth, 56, width of packet bus.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- ADDR_W, 2, log2(DEPTH).
- routerID, 6'b000_000, owning router ID; informational only, not used in logic.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ReqUpStr  in  1  injector request; PacketIn is valid while high.
- PacketIn  in  packetwidth  packet from injector.
- GntUpStr  out  1  one-cycle grant pulse to injector.
- UpStrFull  out  1  FIFO full; wired to the injector's DnStrFull.
- ReqDnStr  out  1  head packet valid (FIFO not empty).
- PacketOut  out  packetwidth  head packet; first-word fall-through.
- GntDnStr  in  1  routing stage consumes the head this cycle.
- Occupancy  out  ADDR_W+1  current entry count, 0..DEPTH.
- PktCount  out  16  packets accepted since reset; wraps 65535→0.

Behaviour:
- Reset: one clock; asynchronous, active-low. All outputs are 0 while reset is low: GntUpStr, UpStrFull, ReqDnStr, PacketOut, Occupancy, PktCount. Pointers clear and FSM enters ACC_IDLE. Reset mid-handshake discards the pending grant and all stored packets.
- Upstream FSM, three states:
  - ACC_IDLE: if ReqUpStr && !UpStrFull at a clock edge, write PacketIn at the write pointer, set GntUpStr=1, increment PktCount, go to ACC_GNT. If full, stay in ACC_IDLE with no grant; ReqUpStr is simply held off.
  - ACC_GNT: GntUpStr returns to 0 at the next edge; go to ACC_REL.
  - ACC_REL: wait until ReqUpStr==0, then go to ACC_IDLE. No write occurs in ACC_GNT or ACC_REL. This prevents double-accepting a request that the injector drops only one cycle after seeing the grant.
- Latency: Req sampled high at edge N → packet stored and GntUpStr high during cycle N+1 → ReqDnStr high in cycle N+1 if the FIFO was empty. Minimum upstream acceptance period is 3 cycles per packet.
- Downstream side:
  - ReqDnStr = (Occupancy != 0); PacketOut = mem[rd_ptr], combinational from registers.
  - GntDnStr && ReqDnStr at an edge pops one entry.
  - GntDnStr while empty is ignored: no pointer or count change.
- Count and flags:
  - Simultaneous push and pop at the same edge leaves Occupancy unchanged; both pointers advance.
  - Push into a full FIFO cannot occur, because the grant is gated by UpStrFull.
  - UpStrFull = (Occupancy == DEPTH), derived from registered count with no extra delay. A pop at edge N frees space, so the grant can be issued at edge N+1.
- Pointers: ADDR_W bits, wrap naturally at DEPTH. Occupancy is tracked as a separate counter, not pointer difference.
- Data: packets pass through bit-exact, with no header modification.

Decomposition:
- Shared package/include: packetwidth; field offsets for PacketID[9:0], ModuleID[5:0], RandomInfo[9:0]; ACC_IDLE/ACC_GNT/ACC_REL state encodings.
- One natural sub-module: sync_fifo_fwft (storage, pointers, occupancy, push/pop). The top-level wraps it with the upstream handshake FSM and PktCount.

Test Plan:
- Single packet: reset, Req=1 with PacketIn=56'h0000_0000_1A2B_3C at edge 0 → GntUpStr pulse in cycle 1 only; PacketOut=56'h..1A2B_3C and ReqDnStr=1 from cycle 1; Occupancy=1; PktCount=1. Injector drops Req in cycle 2 → FSM back to ACC_IDLE in cycle 3, no second write.
- Fill: DEPTH=4, push IDs 1..4 with GntDnStr=0 → UpStrFull=1, Occupancy=4. Fifth Req held high 10 cycles → no grant. Pulse GntDnStr one cycle → Full drops, fifth packet granted next edge; order out is 2,3,4,5.
- Simultaneous: Occupancy=2; grant-write edge coincides with GntDnStr=1 → Occupancy stays 2; head advances to next packet.
- Empty pop: Occupancy=0, GntDnStr=1 for 5 cycles → no change; ReqDnStr=0; pointers unchanged.
- Wrap: stream 10 packets through DEPTH=4 with interleaved pops → all 10 emerge in order, data intact. Separately, force PktCount=65535 and accept one packet → PktCount=0.
- Reset mid-operation: assert reset low while in ACC_GNT with Occupancy=3 → GntUpStr, ReqDnStr, Occupancy immediately 0 (asynchronous). After release, FSM is in ACC_IDLE and the first new Req is granted normally.
